// File: rtl/simmem_row_delay_unit.sv
// Single-bank DRAM row-buffer timing model: classifies each request as a row hit,
// a closed-row access or a row conflict, then holds the completion for cost + AxLen cycles.
module simmem_row_delay_unit #(
  parameter int AddrWidth         = 16,
  parameter int RowBufferLenWidth = 8,
  parameter int IdWidth           = 4,
  parameter int LenWidth          = 8,
  parameter int RowHitCost        = 10,
  parameter int PrechargeCost     = 50,
  parameter int ActivationCost    = 45,
  parameter int StatWidth         = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [AddrWidth-1:0] in_addr_i,
  input  logic [LenWidth-1:0]  in_len_i,
  input  logic [IdWidth-1:0]   in_id_i,
  input  logic                 in_is_write_i,
  output logic                 done_valid_o,
  input  logic                 done_ready_i,
  output logic [IdWidth-1:0]   done_id_o,
  output logic                 done_is_write_o,
  output logic                 done_row_hit_o,
  output logic [StatWidth-1:0] row_hits_o,
  output logic [StatWidth-1:0] row_misses_o
);

  // Worst case 105 + 255 = 360 fits in 10 bits, so the delay sum never wraps.
  localparam int CntWidth = 10;
  localparam logic [CntWidth-1:0] HitCost      = CntWidth'(RowHitCost);
  localparam logic [CntWidth-1:0] ClosedCost   = CntWidth'(ActivationCost + RowHitCost);
  localparam logic [CntWidth-1:0] ConflictCost =
    CntWidth'(PrechargeCost + ActivationCost + RowHitCost);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } state_e;

  state_e                state;
  logic [CntWidth-1:0]   cnt;
  logic                  row_open;
  logic [AddrWidth-1:0]  open_row;
  logic [AddrWidth-1:0]  req_row;
  logic                  req_hit;
  logic                  req_closed;
  logic [CntWidth-1:0]   req_cost;
  logic [CntWidth-1:0]   req_delay;
  logic                  accept;

  function automatic logic [StatWidth-1:0] sat_inc(input logic [StatWidth-1:0] v);
    return (&v) ? v : v + StatWidth'(1);
  endfunction

  // Row index kept at full address width; the shifted-in upper bits are always zero.
  assign req_row    = in_addr_i >> RowBufferLenWidth;
  assign req_hit    = row_open && (req_row == open_row);
  assign req_closed = !row_open;

  always_comb begin
    req_cost = ConflictCost;
    if (req_hit) begin
      req_cost = HitCost;
    end else if (req_closed) begin
      req_cost = ClosedCost;
    end
  end

  assign req_delay    = req_cost + CntWidth'(in_len_i);
  assign accept       = in_valid_i && (state == IDLE);
  assign in_ready_o   = (state == IDLE);
  assign done_valid_o = (state == DONE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state           <= IDLE;
      cnt             <= '0;
      row_open        <= 1'b0;
      open_row        <= '0;
      done_id_o       <= '0;
      done_is_write_o <= 1'b0;
      done_row_hit_o  <= 1'b0;
      row_hits_o      <= '0;
      row_misses_o    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // Loading delay-1 makes DONE appear exactly `delay` edges after acceptance.
            cnt             <= req_delay - CntWidth'(1);
            done_id_o       <= in_id_i;
            done_is_write_o <= in_is_write_i;
            done_row_hit_o  <= req_hit;
            open_row        <= req_row;
            row_open        <= 1'b1;
            state           <= COUNT;
            if (req_hit) begin
              row_hits_o <= sat_inc(row_hits_o);
            end else begin
              row_misses_o <= sat_inc(row_misses_o);
            end
          end
        end
        COUNT: begin
          if (cnt == '0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - CntWidth'(1);
          end
        end
        DONE: begin
          if (done_ready_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simmem_row_delay_unit.sv
// Scoreboard bench for simmem_row_delay_unit: a reference row model predicts hit/miss,
// latency and statistics; a second instance with 2-bit statistics covers saturation.
module tb_simmem_row_delay_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_ready2;
  logic [15:0] in_addr;
  logic [7:0]  in_len;
  logic [3:0]  in_id;
  logic        in_is_write;
  logic        done_valid;
  logic        done_valid2;
  logic        done_ready;
  logic [3:0]  done_id;
  logic [3:0]  done_id2;
  logic        done_is_write;
  logic        done_is_write2;
  logic        done_row_hit;
  logic        done_row_hit2;
  logic [15:0] row_hits;
  logic [15:0] row_misses;
  logic [1:0]  row_hits2;
  logic [1:0]  row_misses2;

  always #5 clk = ~clk;

  simmem_row_delay_unit dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_addr_i(in_addr), .in_len_i(in_len), .in_id_i(in_id), .in_is_write_i(in_is_write),
    .done_valid_o(done_valid), .done_ready_i(done_ready),
    .done_id_o(done_id), .done_is_write_o(done_is_write), .done_row_hit_o(done_row_hit),
    .row_hits_o(row_hits), .row_misses_o(row_misses)
  );

  simmem_row_delay_unit #(.StatWidth(2)) dut_sat (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready2),
    .in_addr_i(in_addr), .in_len_i(in_len), .in_id_i(in_id), .in_is_write_i(in_is_write),
    .done_valid_o(done_valid2), .done_ready_i(done_ready),
    .done_id_o(done_id2), .done_is_write_o(done_is_write2), .done_row_hit_o(done_row_hit2),
    .row_hits_o(row_hits2), .row_misses_o(row_misses2)
  );

  typedef struct {
    logic [3:0] id;
    logic       wr;
    logic       hit;
    int         lat;
    int         t_acc;
  } sb_t;

  sb_t  sb[$];
  sb_t  last;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  // Reference row-buffer model
  logic        m_open;
  logic [15:0] m_row;
  int          m_hits, m_misses, m_hits2, m_misses2;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               tag, got, got, exp, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_open = 1'b0; m_row = '0;
    m_hits = 0; m_misses = 0; m_hits2 = 0; m_misses2 = 0;
  endtask

  task automatic check_stats(input string tag);
    check_eq({tag, "_hits"},    row_hits,    m_hits);
    check_eq({tag, "_misses"},  row_misses,  m_misses);
    check_eq({tag, "_hits2"},   row_hits2,   m_hits2);
    check_eq({tag, "_misses2"}, row_misses2, m_misses2);
  endtask

  // Drives one request until accepted, then records the predicted completion.
  task automatic issue(input logic [15:0] addr, input logic [7:0] len,
                       input logic [3:0] id, input logic wr);
    sb_t         e;
    int          n;
    int          cost;
    logic [15:0] row;
    in_addr = addr; in_len = len; in_id = id; in_is_write = wr; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    check_eq("accept_wait", (n < 1000), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    row = addr >> 8;
    if (!m_open) begin
      cost = 55; e.hit = 1'b0;
    end else if (row == m_row) begin
      cost = 10; e.hit = 1'b1;
    end else begin
      cost = 105; e.hit = 1'b0;
    end
    if (e.hit) begin
      m_hits++;
      if (m_hits2 < 3) m_hits2++;
    end else begin
      m_misses++;
      if (m_misses2 < 3) m_misses2++;
    end
    m_open = 1'b1; m_row = row;
    e.id = id; e.wr = wr; e.lat = cost + int'(len); e.t_acc = cyc;
    sb.push_back(e);
    check_eq("ready_busy", in_ready, 0);
    check_stats("acc");
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done_valid && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    check_eq("done_wait", (n < 1000), 1);
    check_eq("sb_size", sb.size(), 1);
    if (sb.size() != 0) begin
      last = sb.pop_front();
      check_eq("done_id",       done_id,       last.id);
      check_eq("done_is_write", done_is_write, last.wr);
      check_eq("done_row_hit",  done_row_hit,  last.hit);
      check_eq("latency",       cyc - last.t_acc, last.lat);
      check_eq("done_id_sat",   done_id2,      last.id);
      check_eq("done_valid_sat", done_valid2,  1);
    end
  endtask

  task automatic release_done();
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    check_eq("rel_done_valid", done_valid, 0);
    check_eq("rel_in_ready",   in_ready,   1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    model_reset();
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_len = '0; in_id = '0;
    in_is_write = 1'b0; done_ready = 1'b0;
    model_reset();
    #3;
    check_eq("rst_in_ready",   in_ready,      1);
    check_eq("rst_done_valid", done_valid,    0);
    check_eq("rst_done_id",    done_id,       0);
    check_eq("rst_done_wr",    done_is_write, 0);
    check_eq("rst_done_hit",   done_row_hit,  0);
    check_stats("rst");
    @(posedge clk); #1;
    rst = 1'b0;

    // Closed, hit with stall, conflict
    issue(16'h0100, 8'd0, 4'd3, 1'b0);
    wait_done();
    release_done();
    issue(16'h01FF, 8'd3, 4'd5, 1'b1);
    wait_done();
    in_addr = 16'h0900; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("stall_valid", done_valid,    1);
      check_eq("stall_id",    done_id,       last.id);
      check_eq("stall_wr",    done_is_write, last.wr);
      check_eq("stall_hit",   done_row_hit,  last.hit);
      check_eq("stall_ready", in_ready,      0);
    end
    in_valid = 1'b0;
    check_stats("stall");
    release_done();
    issue(16'h0200, 8'd0, 4'd9, 1'b0);
    wait_done();
    release_done();

    // Reset in the middle of counting discards the request
    issue(16'h0200, 8'd0, 4'd1, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("midrst_done_valid", done_valid, 0);
    check_eq("midrst_in_ready",   in_ready,   1);
    check_eq("midrst_hits",       row_hits,   0);
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    model_reset();
    seen = 0;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk); #1;
      if (done_valid) seen++;
    end
    check_eq("no_ghost_done", seen, 0);
    issue(16'h0200, 8'd0, 4'd1, 1'b1);
    wait_done();
    release_done();

    // Reset while a completion is waiting in DONE
    issue(16'h0200, 8'd0, 4'd2, 1'b0);
    wait_done();
    #2;
    rst = 1'b1;
    #1;
    check_eq("donerst_valid", done_valid,   0);
    check_eq("donerst_id",    done_id,      0);
    check_eq("donerst_hit",   done_row_hit, 0);
    check_eq("donerst_ready", in_ready,     1);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    issue(16'h0200, 8'd2, 4'd6, 1'b1);
    wait_done();
    release_done();

    // Longest delay: conflict with maximum burst length
    issue(16'hFF00, 8'd255, 4'd15, 1'b0);
    wait_done();
    release_done();

    // Statistic saturation on the 2-bit instance
    pulse_reset();
    issue(16'h0100, 8'd0, 4'd7, 1'b0);
    wait_done();
    release_done();
    for (int i = 0; i < 4; i++) begin
      issue(16'h0110 + 16'(i), 8'd0, 4'(i), 1'b0);
      wait_done();
      release_done();
    end
    check_eq("sat_hits2",   row_hits2,   3);
    check_eq("sat_misses2", row_misses2, 1);
    check_eq("wide_hits",   row_hits,    4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
